// File: rtl/sample_pkg.sv
// Shared constants and helpers for the sample_pipe benchmark pipeline.
package sample_pkg;

    localparam int SAMPLE_W_DEF     = 8;
    localparam int SAMPLE_CNT_W_DEF = 16;

    // Widest vector popcount() accepts; wider lanes are truncated.
    localparam int SAMPLE_VEC_MAX   = 64;

    // Increment value by one, holding at 2^width-1 (width up to 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

    // Number of set bits in vec.
    function automatic logic [31:0] popcount(input logic [SAMPLE_VEC_MAX-1:0] vec);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < SAMPLE_VEC_MAX; i++) begin
            n = n + {31'd0, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sample_pipe_slice.sv
// One elastic register slice: a single payload register with valid/ready on
// both sides and full throughput (accepts while its own content leaves).
module sample_pipe_slice
    import sample_pkg::*;
#(
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [P-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [P-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [P-1:0] data_q, data_d;
    logic         load;

    // Ready when empty or when the held item leaves this cycle; load on accept,
    // drop valid when the item leaves with nothing new behind it.
    always_comb begin
        in_ready_o = ~valid_q | out_ready_i;
        load       = in_valid_i & in_ready_o;
        valid_d    = valid_q;
        data_d     = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slice state; asynchronous active-low clear discards the held item.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/sample_pipe.sv
// Two-stage pipelined version of the sample boolean network:
//   r = ((x&y&z)|u|w) & (v|x|y),  s = u&w,  t = ~z   (bitwise over W lanes)
// plus a saturating count of output transfers.
// Optional macro SAMPLE_PIPE_STATS_EN adds r_ones, a saturating running
// popcount of r over all output transfers.
//
// Handshake: a transfer happens at a rising clk edge where valid & ready are
// both high; valid never waits on ready, a source holds valid and data stable
// until the transfer, and ready may depend combinationally on downstream ready.
module sample_pipe
    import sample_pkg::*;
#(
    parameter int W     = SAMPLE_W_DEF,
    parameter int CNT_W = SAMPLE_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic [W-1:0]     z,
    input  logic [W-1:0]     u,
    input  logic [W-1:0]     v,
    input  logic [W-1:0]     w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     r,
    output logic [W-1:0]     s,
    output logic [W-1:0]     t,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef SAMPLE_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0] r_ones
`endif
);

    localparam int P1 = 5 * W;
    localparam int P2 = 3 * W;

    logic [P1-1:0] s1_in, s1_out;
    logic [P2-1:0] s2_in, s2_out;
    logic          v1;
    logic          s2_ready;
    logic [W-1:0]  n1, m1, uw1, s1, t1;
    logic          xfer_fire;

    // First half of the network: partial terms captured by stage 1.
    assign s1_in = {x & y & z, v | x | y, u | w, u & w, ~z};
    assign {n1, m1, uw1, s1, t1} = s1_out;

    // Second half of the network: final r, s and t pass straight through.
    assign s2_in = {(n1 | uw1) & m1, s1, t1};

    sample_pipe_slice #(.P(P1)) u_stage1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (s1_in),
        .out_valid_o (v1),
        .out_ready_i (s2_ready),
        .out_data_o  (s1_out)
    );

    sample_pipe_slice #(.P(P2)) u_stage2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (v1),
        .in_ready_o  (s2_ready),
        .in_data_i   (s2_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s2_out)
    );

    assign {r, s, t} = s2_out;
    assign xfer_fire = out_valid & out_ready;

    logic [CNT_W-1:0] xfer_q, xfer_d;

    // Count output transfers, sticking at the all-ones value.
    always_comb begin
        xfer_d = xfer_q;
        if (xfer_fire) begin
            xfer_d = CNT_W'(sat_inc(32'(xfer_q), CNT_W));
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_q <= '0;
        end else begin
            xfer_q <= xfer_d;
        end
    end

    assign xfer_cnt = xfer_q;

`ifdef SAMPLE_PIPE_STATS_EN
    // Sum is formed in 33 bits so it cannot wrap before the clamp (CNT_W <= 32).
    localparam logic [32:0] ONES_MAX = (33'd1 << CNT_W) - 33'd1;

    logic [CNT_W-1:0] r_ones_q, r_ones_d;
    logic [32:0]      ones_sum;

    // Accumulate popcount(r) per output transfer, clamped at the maximum.
    always_comb begin
        ones_sum = {1'b0, 32'(r_ones_q)} + {1'b0, popcount(SAMPLE_VEC_MAX'(r))};
        r_ones_d = r_ones_q;
        if (xfer_fire) begin
            r_ones_d = (ones_sum > ONES_MAX) ? CNT_W'(ONES_MAX) : CNT_W'(ones_sum);
        end
    end

    // Popcount accumulator register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ones_q <= '0;
        end else begin
            r_ones_q <= r_ones_d;
        end
    end

    assign r_ones = r_ones_q;
`endif

endmodule

// File: tb/tb_sample_pipe.sv
// Self-checking bench for sample_pipe: a main instance (CNT_W=16) and a
// narrow-counter instance (CNT_W=4) share all inputs.
module tb_sample_pipe;

    localparam int W         = 8;
    localparam int CNT_W     = 16;
    localparam int SAT_CNT_W = 4;

    // ---------------- clock / reset / signals ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     x = '0, y = '0, z = '0, u = '0, v = '0, w = '0;
    logic             in_ready, out_valid;
    logic [W-1:0]     r, s, t;
    logic [CNT_W-1:0] xfer_cnt;
    logic             sat_in_ready, sat_out_valid;
    logic [W-1:0]     sat_r, sat_s, sat_t;
    logic [SAT_CNT_W-1:0] sat_xfer_cnt;
`ifdef SAMPLE_PIPE_STATS_EN
    logic [CNT_W-1:0]     r_ones;
    logic [SAT_CNT_W-1:0] sat_r_ones;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [3*W-1:0] exp_q[$];

    sample_pipe #(.W(W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z(z), .u(u), .v(v), .w(w),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .s(s), .t(t), .xfer_cnt(xfer_cnt)
`ifdef SAMPLE_PIPE_STATS_EN
        , .r_ones(r_ones)
`endif
    );

    sample_pipe #(.W(W), .CNT_W(SAT_CNT_W)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .x(x), .y(y), .z(z), .u(u), .v(v), .w(w),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .r(sat_r), .s(sat_s), .t(sat_t), .xfer_cnt(sat_xfer_cnt)
`ifdef SAMPLE_PIPE_STATS_EN
        , .r_ones(sat_r_ones)
`endif
    );

    // Reference network, written directly from the boolean equations.
    function automatic logic [3*W-1:0] model(input logic [W-1:0] a_x, a_y, a_z, a_u, a_v, a_w);
        return {((a_x & a_y & a_z) | a_u | a_w) & (a_v | a_x | a_y), a_u & a_w, ~a_z};
    endfunction

    // ---------------- driver tasks ----------------
    // Leaves the bench at posedge+1 with reset released and inputs idle.
    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        {x, y, z, u, v, w} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic rand_ops();
        x = W'($urandom_range(0, 255));
        y = W'($urandom_range(0, 255));
        z = W'($urandom_range(0, 255));
        u = W'($urandom_range(0, 255));
        v = W'($urandom_range(0, 255));
        w = W'($urandom_range(0, 255));
    endtask

    // Called at posedge+1 after inputs are set; samples handshakes at posedge+2.
    task automatic observe(output logic in_fire, output logic out_fire);
        #1;
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if ({r, s, t} !== '0) begin errors++; $display("FAIL reset_rst: got %h expected 0", {r, s, t}); end
        checks++; if (xfer_cnt !== '0) begin errors++; $display("FAIL reset_xfer_cnt: got %0d expected 0", xfer_cnt); end
    endtask

    task automatic test_single_beat(input string name,
                                    input logic [W-1:0] a_x, a_y, a_z, a_u, a_v, a_w,
                                    input logic [W-1:0] e_r, e_s, e_t);
        logic inf, outf;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        {x, y, z, u, v, w} = {a_x, a_y, a_z, a_u, a_v, a_w};
        observe(inf, outf);
        checks++; if (inf !== 1'b1) begin errors++; $display("FAIL %s_accept: got %b expected 1", name, inf); end
        next_cycle();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid: got %b expected 0", name, out_valid); end
        next_cycle();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", name, out_valid); end
        checks++; if (r !== e_r) begin errors++; $display("FAIL %s_r: got %h expected %h", name, r, e_r); end
        checks++; if (s !== e_s) begin errors++; $display("FAIL %s_s: got %h expected %h", name, s, e_s); end
        checks++; if (t !== e_t) begin errors++; $display("FAIL %s_t: got %h expected %h", name, t, e_t); end
        next_cycle();
        #1;
        checks++; if (xfer_cnt !== CNT_W'(1)) begin errors++; $display("FAIL %s_xfer_cnt: got %0d expected 1", name, xfer_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained: got %b expected 0", name, out_valid); end
    endtask

    task automatic test_backpressure();
        logic inf, outf;
        logic [3*W-1:0] exp;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            rand_ops();
            observe(inf, outf);
            if (i < 2) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d: got %b expected 1", i, in_ready); end
                exp_q.push_back(model(x, y, z, u, v, w));
                next_cycle();
            end else begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
            end
        end
        // Stall with beat 2 held at the input; output must keep beat 0.
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready%0d: got %b expected 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || {r, s, t} !== exp_q[0]) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b %h expected v=1 %h", c, out_valid, {r, s, t}, exp_q[0]);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            observe(inf, outf);
            if (inf) exp_q.push_back(model(x, y, z, u, v, w));
            checks++;
            if (!outf) begin
                errors++; $display("FAIL bp_drain%0d: got out_valid=%b expected 1", c, out_valid);
            end else if (exp_q.size() == 0) begin
                errors++; $display("FAIL bp_drain%0d: got %h expected no output", c, {r, s, t});
            end else begin
                exp = exp_q.pop_front();
                if ({r, s, t} !== exp) begin errors++; $display("FAIL bp_drain%0d: got %h expected %h", c, {r, s, t}, exp); end
            end
            next_cycle();
            if (inf) in_valid = 1'b0;
        end
        #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover: got %0d expected 0", exp_q.size()); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_valid: got %b expected 0", out_valid); end
        checks++; if (xfer_cnt !== CNT_W'(3)) begin errors++; $display("FAIL bp_xfer_cnt: got %0d expected 3", xfer_cnt); end
    endtask

    task automatic test_back_to_back();
        logic inf, outf;
        logic [3*W-1:0] exp;
        int accepted, outs, cyc;
        do_reset();
        accepted = 0;
        outs = 0;
        cyc = 0;
        rand_ops();
        while ((accepted < 100 || exp_q.size() > 0) && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (accepted < 100);
            observe(inf, outf);
            if (inf) begin
                exp_q.push_back(model(x, y, z, u, v, w));
                accepted++;
            end
            if (outf) begin
                outs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_dup: got %h expected no output", {r, s, t});
                end else begin
                    exp = exp_q.pop_front();
                    if ({r, s, t} !== exp) begin errors++; $display("FAIL stream_data%0d: got %h expected %h", outs, {r, s, t}, exp); end
                end
            end
            next_cycle();
            if (inf) rand_ops();
            cyc++;
        end
        in_valid = 1'b0;
        #1;
        checks++; if (cyc >= 3000) begin errors++; $display("FAIL stream_timeout: got %0d cycles expected < 3000", cyc); end
        checks++; if (outs != 100) begin errors++; $display("FAIL stream_count: got %0d expected 100", outs); end
        checks++; if (xfer_cnt !== CNT_W'(100)) begin errors++; $display("FAIL stream_xfer_cnt: got %0d expected 100", xfer_cnt); end
    endtask

    task automatic test_async_reset();
        logic inf, outf;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        rand_ops();
        next_cycle();
        rand_ops();
        next_cycle();
        in_valid = 1'b0;
        repeat (3) next_cycle();
        #1;
        checks++; if (xfer_cnt !== CNT_W'(2)) begin errors++; $display("FAIL areset_pre_cnt: got %0d expected 2", xfer_cnt); end
        // Fill both stages with the output stalled.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_ops();
        next_cycle();
        rand_ops();
        next_cycle();
        in_valid = 1'b1;
        observe(inf, outf);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL areset_full: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
        end
        // Mid-cycle, far from any edge.
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({r, s, t} !== '0) begin errors++; $display("FAIL areset_rst: got %h expected 0", {r, s, t}); end
        checks++; if (xfer_cnt !== '0) begin errors++; $display("FAIL areset_xfer_cnt: got %0d expected 0", xfer_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
        checks++; if (sat_xfer_cnt !== '0) begin errors++; $display("FAIL areset_sat_cnt: got %0d expected 0", sat_xfer_cnt); end
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_saturation();
        logic inf, outf;
        int sent, exp_cnt, cyc;
        int exp_sat;
        do_reset();
        out_ready = 1'b1;
        {x, y, z} = {W'(8'hFF), W'(8'hFF), W'(8'hFF)};
        {u, v, w} = '0;
        sent = 0;
        exp_cnt = 0;
        for (cyc = 0; cyc < 26; cyc++) begin
            in_valid = (sent < 20);
            observe(inf, outf);
            if (inf) sent++;
            if (outf) exp_cnt++;
            next_cycle();
            exp_sat = (exp_cnt > 15) ? 15 : exp_cnt;
            checks++; if (int'(sat_xfer_cnt) != exp_sat) begin
                errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", cyc, sat_xfer_cnt, exp_sat);
            end
        end
        checks++; if (exp_cnt != 20) begin errors++; $display("FAIL sat_total: got %0d expected 20", exp_cnt); end
        checks++; if (sat_xfer_cnt !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d expected 15", sat_xfer_cnt); end
        checks++; if (xfer_cnt !== CNT_W'(20)) begin errors++; $display("FAIL sat_wide_cnt: got %0d expected 20", xfer_cnt); end
`ifdef SAMPLE_PIPE_STATS_EN
        checks++; if (r_ones !== CNT_W'(160)) begin errors++; $display("FAIL stats_ones: got %0d expected 160", r_ones); end
        checks++; if (sat_r_ones !== 4'd15) begin errors++; $display("FAIL stats_sat_ones: got %0d expected 15", sat_r_ones); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_beat("beat_a", 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'hF0);
        test_single_beat("beat_b", 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3C, 8'h0F, 8'h2C, 8'h05, 8'hFF);
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
